lfsr_rand_gen: RTL and testbench

//  Parametrised Fibonacci LFSR random-word generator with a req/ack handshake.

---
 rtl/lfsr_pkg.sv | 15 +
 rtl/lfsr_core.sv | 32 +++
 rtl/lfsr_rand_gen.sv | 119 +++++++++++
 tb/tb_lfsr_rand_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types, default constants and step function for the LFSR random generator
package lfsr_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  localparam int         DEF_WIDTH = 8;
  localparam logic [7:0] DEF_TAPS  = 8'h8E;
  localparam logic [7:0] DEF_SEED  = 8'hBD;

  // Generic Fibonacci step on a 32-bit container; callers truncate to their width.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] taps);
    return {s[30:0], ^(s & taps)};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - WIDTH-bit LFSR register with step enable, seed load and all-zero repair
import lfsr_pkg::*;

module lfsr_core #(
  parameter int               WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = DEF_TAPS,
  parameter logic [WIDTH-1:0] SEED  = DEF_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] lfsr,
  output logic [WIDTH-1:0] nxt
);

  assign nxt = WIDTH'(lfsr_step(32'(lfsr), 32'(TAPS)));

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
    end else if (load) begin
      lfsr <= (load_val == '0) ? SEED : load_val;
    end else if (lfsr == '0) begin
      lfsr <= SEED;
    end else if (step_en) begin
      lfsr <= nxt;
    end
  end

endmodule

// File: rtl/lfsr_rand_gen.sv
// rtl/lfsr_rand_gen.sv - req/ack random word generator; LFSR_REJECT_EN adds max_val range rejection
import lfsr_pkg::*;

module lfsr_rand_gen #(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS     = DEF_TAPS,
  parameter logic [WIDTH-1:0] SEED     = DEF_SEED,
  parameter int               OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                ack,
  input  logic                seed_load,
  input  logic [WIDTH-1:0]    seed_in,
`ifdef LFSR_REJECT_EN
  input  logic [OUT_BITS-1:0] max_val,
`endif
  output logic [OUT_BITS-1:0] rnd_data,
  output logic                rnd_valid,
  output logic                busy,
  output logic                lockup
);

  localparam int            CW       = $clog2(OUT_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OUT_BITS);

  logic [WIDTH-1:0]    lfsr, nxt;
  logic                zero, step_en, word_ok;
  logic [OUT_BITS-1:0] word;
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [OUT_BITS-1:0] data_q, data_d;

  assign zero    = (lfsr == '0);
  assign step_en = (state_q == SHIFT) && !seed_load && !zero;
  assign word    = nxt[WIDTH-1 -: OUT_BITS];
  assign cnt_inc = cnt_q + CW'(1);

  lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED)) u_core (
    .clk      (clk),
    .rst      (rst),
    .step_en  (step_en),
    .load     (seed_load),
    .load_val (seed_in),
    .lfsr     (lfsr),
    .nxt      (nxt)
  );

`ifdef LFSR_REJECT_EN
  // The bound is captured when a request is accepted so it cannot change mid-word.
  logic                accept;
  logic [OUT_BITS-1:0] max_q;
  assign accept  = !seed_load && !zero && req &&
                   ((state_q == IDLE) || ((state_q == HOLD) && ack));
  assign word_ok = (word <= max_q);
  always_ff @(posedge clk) begin
    if (rst)         max_q <= '0;
    else if (accept) max_q <= max_val;
  end
`else
  assign word_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      lockup  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      lockup  <= zero && !seed_load;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    if (seed_load) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (!zero) begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_LAST) begin
            cnt_d = '0;
            if (word_ok) begin
              data_d  = word;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (ack) begin
            cnt_d   = '0;
            state_d = req ? SHIFT : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rnd_data  = data_q;
  assign rnd_valid = (state_q == HOLD);
  assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// tb/tb_lfsr_rand_gen.sv - self-checking bench for lfsr_rand_gen against a word-level reference model
module tb_lfsr_rand_gen;

  localparam int         WIDTH    = 8;
  localparam logic [7:0] TAPS_V   = 8'h8E;
  localparam logic [7:0] SEED_V   = 8'hBD;
  localparam int         OUT_BITS = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                req = 1'b0;
  logic                ack = 1'b0;
  logic                seed_load = 1'b0;
  logic [WIDTH-1:0]    seed_in = '0;
  logic [OUT_BITS-1:0] max_val = '1;
  logic [OUT_BITS-1:0] rnd_data;
  logic                rnd_valid, busy, lockup;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lfsr_rand_gen #(.WIDTH(WIDTH), .TAPS(TAPS_V), .SEED(SEED_V), .OUT_BITS(OUT_BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ack       (ack),
    .seed_load (seed_load),
    .seed_in   (seed_in),
`ifdef LFSR_REJECT_EN
    .max_val   (max_val),
`endif
    .rnd_data  (rnd_data),
    .rnd_valid (rnd_valid),
    .busy      (busy),
    .lockup    (lockup)
  );

  // Reference: count tapped ones, feedback is their parity, shift left by doubling.
  function automatic logic [7:0] ref_step(input logic [7:0] s);
    logic [7:0] t;
    int ones;
    t = TAPS_V;
    ones = 0;
    for (int i = 0; i < 8; i++) if (t[i] && s[i]) ones++;
    return 8'((int'(s) * 2 + ones % 2) % 256);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 1'b0; ack = 1'b0; seed_load = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (rnd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rnd_valid); end
    if (rnd_data !== 2'b00) begin errors++; $display("FAIL reset_data got=%b exp=00", rnd_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (lockup !== 1'b0) begin errors++; $display("FAIL reset_lockup got=%b exp=0", lockup); end
    if (dut.u_core.lfsr !== SEED_V) begin errors++; $display("FAIL reset_lfsr got=%h exp=%h", dut.u_core.lfsr, SEED_V); end
  endtask

  task automatic test_first_word();
    req = 1'b1;
    tick();
    req = 1'b0;
    checks += 3;
    if (busy !== 1'b1) begin errors++; $display("FAIL first_busy0 got=%b exp=1", busy); end
    if (rnd_valid !== 1'b0) begin errors++; $display("FAIL first_valid0 got=%b exp=0", rnd_valid); end
    if (dut.u_core.lfsr !== 8'hBD) begin errors++; $display("FAIL first_lfsr0 got=%h exp=bd", dut.u_core.lfsr); end
    tick();
    checks += 3;
    if (busy !== 1'b1) begin errors++; $display("FAIL first_busy1 got=%b exp=1", busy); end
    if (rnd_valid !== 1'b0) begin errors++; $display("FAIL first_valid1 got=%b exp=0", rnd_valid); end
    if (dut.u_core.lfsr !== 8'h7B) begin errors++; $display("FAIL first_lfsr1 got=%h exp=7b", dut.u_core.lfsr); end
    tick();
    checks += 4;
    if (rnd_valid !== 1'b1) begin errors++; $display("FAIL first_valid2 got=%b exp=1", rnd_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL first_busy2 got=%b exp=0", busy); end
    if (rnd_data !== 2'b11) begin errors++; $display("FAIL first_data got=%b exp=11", rnd_data); end
    if (dut.u_core.lfsr !== 8'hF6) begin errors++; $display("FAIL first_lfsr2 got=%h exp=f6", dut.u_core.lfsr); end
  endtask

  task automatic test_hold_back_to_back();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks += 3;
      if (rnd_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", i, rnd_valid); end
      if (rnd_data !== 2'b11) begin errors++; $display("FAIL hold_data cyc=%0d got=%b exp=11", i, rnd_data); end
      if (dut.u_core.lfsr !== 8'hF6) begin errors++; $display("FAIL hold_lfsr cyc=%0d got=%h exp=f6", i, dut.u_core.lfsr); end
    end
    ack = 1'b1; req = 1'b1;
    tick();
    ack = 1'b0; req = 1'b0;
    checks += 2;
    if (rnd_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_low got=%b exp=0", rnd_valid); end
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    tick();
    checks++;
    if (dut.u_core.lfsr !== 8'hED) begin errors++; $display("FAIL b2b_lfsr1 got=%h exp=ed", dut.u_core.lfsr); end
    tick();
    checks += 3;
    if (rnd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b exp=1", rnd_valid); end
    if (rnd_data !== 2'b11) begin errors++; $display("FAIL b2b_data got=%b exp=11", rnd_data); end
    if (dut.u_core.lfsr !== 8'hDB) begin errors++; $display("FAIL b2b_lfsr2 got=%h exp=db", dut.u_core.lfsr); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (rnd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ack_to_idle valid=%b busy=%b exp=0,0", rnd_valid, busy); end
  endtask

  task automatic test_seed_load_in_shift();
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    seed_load = 1'b1; seed_in = 8'h00; req = 1'b1;
    tick();
    seed_load = 1'b0; req = 1'b0;
    checks += 3;
    if (dut.u_core.lfsr !== SEED_V) begin errors++; $display("FAIL seed0_lfsr got=%h exp=%h", dut.u_core.lfsr, SEED_V); end
    if (rnd_valid !== 1'b0) begin errors++; $display("FAIL seed0_valid got=%b exp=0", rnd_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL seed0_idle busy=%b exp=0", busy); end
    req = 1'b1;
    tick();
    req = 1'b0;
    tick(); tick();
    checks += 2;
    if (rnd_valid !== 1'b1) begin errors++; $display("FAIL seed0_rerun_valid got=%b exp=1", rnd_valid); end
    if (rnd_data !== 2'b11) begin errors++; $display("FAIL seed0_rerun_data got=%b exp=11", rnd_data); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_lockup();
    dut.u_core.lfsr = 8'h00;
    tick();
    checks += 2;
    if (lockup !== 1'b1) begin errors++; $display("FAIL lockup_pulse got=%b exp=1", lockup); end
    if (dut.u_core.lfsr !== SEED_V) begin errors++; $display("FAIL lockup_lfsr got=%h exp=%h", dut.u_core.lfsr, SEED_V); end
    tick();
    checks += 2;
    if (lockup !== 1'b0) begin errors++; $display("FAIL lockup_width got=%b exp=0", lockup); end
    if (dut.u_core.lfsr !== SEED_V) begin errors++; $display("FAIL lockup_idle_lfsr got=%h exp=%h", dut.u_core.lfsr, SEED_V); end
  endtask

  task automatic test_random();
    logic [7:0] m;
    logic [OUT_BITS-1:0] exp_w;
    logic in_hold;
    int lat;
    do_reset();
    m = SEED_V;
    in_hold = 1'b0;
    for (int it = 0; it < 40; it++) begin
      if (!in_hold && ($urandom_range(0, 3) == 0)) begin
        seed_in = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        m = (seed_in == 8'h00) ? SEED_V : seed_in;
      end
      if (in_hold) ack = 1'b1;
      req = 1'b1;
      tick();
      req = 1'b0; ack = 1'b0;
      lat = 0;
      while (rnd_valid !== 1'b1 && lat < 20) begin
        tick();
        lat++;
      end
      for (int s = 0; s < OUT_BITS; s++) m = ref_step(m);
      exp_w = OUT_BITS'(m >> (WIDTH - OUT_BITS));
      checks += 3;
      if (lat != OUT_BITS) begin errors++; $display("FAIL rnd_latency it=%0d got=%0d exp=%0d", it, lat, OUT_BITS); end
      if (rnd_data !== exp_w) begin errors++; $display("FAIL rnd_data it=%0d got=%b exp=%b", it, rnd_data, exp_w); end
      if (dut.u_core.lfsr !== m) begin errors++; $display("FAIL rnd_lfsr it=%0d got=%h exp=%h", it, dut.u_core.lfsr, m); end
      repeat ($urandom_range(0, 3)) tick();
      checks++;
      if (rnd_data !== exp_w || rnd_valid !== 1'b1) begin
        errors++; $display("FAIL rnd_hold it=%0d data=%b valid=%b exp=%b,1", it, rnd_data, rnd_valid, exp_w);
      end
      in_hold = 1'($urandom_range(0, 1));
      if (!in_hold) begin
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (rnd_valid !== 1'b0) begin errors++; $display("FAIL rnd_release it=%0d got=%b exp=0", it, rnd_valid); end
      end
    end
    if (in_hold) begin
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end
  endtask

  task automatic test_reset_in_hold();
    req = 1'b1;
    tick();
    req = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 4;
    if (rnd_valid !== 1'b0) begin errors++; $display("FAIL rsthold_valid got=%b exp=0", rnd_valid); end
    if (rnd_data !== 2'b00) begin errors++; $display("FAIL rsthold_data got=%b exp=00", rnd_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rsthold_busy got=%b exp=0", busy); end
    if (dut.u_core.lfsr !== SEED_V) begin errors++; $display("FAIL rsthold_lfsr got=%h exp=%h", dut.u_core.lfsr, SEED_V); end
  endtask

`ifdef LFSR_REJECT_EN
  task automatic test_reject();
    int lat;
    do_reset();
    max_val = 2'b10;
    req = 1'b1;
    tick();
    req = 1'b0;
    lat = 0;
    while (rnd_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    checks += 3;
    if (lat != 6) begin errors++; $display("FAIL reject_latency got=%0d exp=6", lat); end
    if (rnd_data !== 2'b01) begin errors++; $display("FAIL reject_data got=%b exp=01", rnd_data); end
    if (dut.u_core.lfsr !== 8'h6F) begin errors++; $display("FAIL reject_lfsr got=%h exp=6f", dut.u_core.lfsr); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    max_val = '1;
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_first_word();
    test_hold_back_to_back();
    test_seed_load_in_shift();
    test_lockup();
    test_reset_in_hold();
`ifdef LFSR_REJECT_EN
    test_reject();
`else
    test_random();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
